mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply / divide unit with HI/LO result registers.
//
// One iteration per cycle (shift-add multiply, restoring divide) on operand
// magnitudes, followed by a single sign-correction cycle that writes HI/LO.
// A request is accepted only in IDLE. done pulses for one cycle 33 cycles after
// the accepting edge, and a new start in that cycle is accepted.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   start     request pulse, sampled only in IDLE
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b      multiplicand/dividend, multiplier/divisor
//   busy      high whenever the FSM is not in IDLE
//   done      one-cycle pulse, hi/lo valid while high
//   div_zero  pulse with done when a divide had b = 0
//   hi, lo    product upper/lower, or remainder/quotient
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold last result
// RUN   | one multiply/divide iteration per cycle, counter 0..31
// FIX   | sign correction, hi/lo write, done/div_zero registered
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_is_div;
  logic             r_neg_a;
  logic             r_neg_b;
  logic             r_b_zero;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_div_zero;

  logic             w_signed_op;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  // op[0] = 0 selects the signed variants (MULT, DIV)
  assign w_signed_op = ~op[0];
  assign w_a_mag     = (w_signed_op && a[WIDTH-1]) ? -a : a;
  assign w_b_mag     = (w_signed_op && b[WIDTH-1]) ? -b : b;

  // Multiply: {acc_hi, acc_lo} shifts right; acc_lo starts as one operand and
  // its LSB decides whether the other operand is added into the upper half.
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);

  // Restoring divide: acc_hi is the partial remainder, acc_lo shifts the
  // dividend out and the quotient in. The remainder stays below the divisor,
  // so the 33-bit trial never overflows; a zero divisor never borrows, which
  // leaves the dividend magnitude in acc_hi.
  assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};

  assign w_prod_neg = -{r_acc_hi, r_acc_lo};

  always_comb begin
    w_fix_hi = r_acc_hi;
    w_fix_lo = r_acc_lo;
    if (r_is_div) begin
      w_fix_lo = (r_neg_a ^ r_neg_b) ? -r_acc_lo : r_acc_lo;
      w_fix_hi = r_neg_a ? -r_acc_hi : r_acc_hi;
      // remainder carries the sign of a, so hi reproduces a exactly here
      if (r_b_zero) w_fix_lo = '1;
    end else if (r_neg_a ^ r_neg_b) begin
      {w_fix_hi, w_fix_lo} = w_prod_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == CNT_LAST) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_div   <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_b_zero   <= 1'b0;
      r_cnt      <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_opb      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= op[1];
            r_neg_a  <= w_signed_op & a[WIDTH-1];
            r_neg_b  <= w_signed_op & b[WIDTH-1];
            r_b_zero <= (b == '0);
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= w_a_mag;
            r_opb    <= w_b_mag;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            if (!w_div_diff[WIDTH]) begin
              r_acc_hi <= w_div_diff[WIDTH-1:0];
              r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              r_acc_hi <= w_div_shift[WIDTH-1:0];
              r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_acc_hi <= w_mul_sum[WIDTH:1];
            r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_hi       <= w_fix_hi;
          r_lo       <= w_fix_lo;
          r_done     <= 1'b1;
          r_div_zero <= r_is_div & r_b_zero;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
